serv_mem_sched: RTL
===================

SERV_MEM_SCHED -- requirements
Module: serv_mem_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: grant cycles without i_mem_ack before an error ack is issued; legal range 0..255; 0 disables the timeout.
REQ-002 SHALL have parameter RR, default 1: 1 selects round-robin tie-break, 0 selects fixed dbus priority.
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_ibus_adr  in  32  instruction fetch address.
REQ-006 i_ibus_cyc  in  1  fetch request; held high until o_ibus_ack.
REQ-007 o_ibus_rdt  out  32  fetch read data.
REQ-008 o_ibus_ack  out  1  fetch completion strobe, one cycle.
REQ-009 i_dbus_adr  in  32  data address.
REQ-010 i_dbus_dat  in  32  write data.
REQ-011 i_dbus_sel  in  4  byte enables.
REQ-012 i_dbus_we  in  1  write enable.
REQ-013 i_dbus_cyc  in  1  data request; held high until o_dbus_ack.
REQ-014 o_dbus_rdt  out  32  data read data.
REQ-015 o_dbus_ack  out  1  data completion strobe, one cycle.
REQ-016 o_mem_adr, o_mem_dat, o_mem_sel, o_mem_we  out  32/32/4/1  shared memory port request fields.
REQ-017 o_mem_cyc  out  1  shared port request valid.
REQ-018 i_mem_rdt  in  32  memory read data.
REQ-019 i_mem_ack  in  1  memory completion strobe.
REQ-020 o_err  out  1  one-cycle pulse on timeout.
REQ-021 o_owner  out  1  current or last grant: 0 = ibus, 1 = dbus.

Function
REQ-022 SHALL implement the FSM states IDLE, GNT_I and GNT_D, with o_mem_cyc = 1 exactly in the GNT states.
REQ-023 In IDLE with only i_ibus_cyc high, the FSM SHALL go to GNT_I next cycle; with only i_dbus_cyc high, it SHALL go to GNT_D next cycle.
REQ-024 In IDLE with both requests high: when RR=1, the FSM SHALL grant the requester not equal to o_owner; when RR=0, it SHALL grant dbus.
REQ-025 On entry to a GNT state, the block SHALL register the owner's adr/dat/sel/we into o_mem_*; these SHALL stay stable for the whole grant, with ibus driving dat=0, sel=4'hF, we=0.
REQ-026 A grant SHALL never be preempted; the other requester waits in IDLE arbitration.
REQ-027 When i_mem_ack is high in a GNT state, the block SHALL, in the same cycle (combinationally), assert the owner's ack with rdt = i_mem_rdt, provided that owner's cyc is high; next state is IDLE.
REQ-028 The non-owner's ack SHALL be 0 and its rdt SHALL be 0 at all times.
REQ-029 A requester whose cyc drops mid-grant (abort) SHALL NOT terminate the grant; the grant ends on i_mem_ack or timeout, and that ack SHALL be suppressed.
REQ-030 The timeout counter SHALL be 8 bits, cleared on GNT entry and incremented each GNT cycle without i_mem_ack.
REQ-031 With TIMEOUT != 0, when the counter equals TIMEOUT-1 and i_mem_ack is low, the block SHALL assert the owner's ack with rdt=0 and o_err=1 for one cycle, then go to IDLE.
REQ-032 If i_mem_ack and the timeout coincide, i_mem_ack SHALL win and o_err SHALL stay 0.
REQ-033 Every grant SHALL take at least one IDLE cycle, giving a minimum latency of request-to-ack of 2 cycles (request seen, then GNT with same-cycle ack).
REQ-034 i_mem_ack in IDLE SHALL be ignored.

Reset
REQ-035 While i_rst_n=0, the FSM SHALL be in IDLE, with o_mem_cyc=0, o_mem_adr/dat/sel/we=0, counter=0, o_err=0, o_owner=1 (so that ibus wins the first tie), and both acks 0.
REQ-036 Reset asserted mid-grant SHALL drop o_mem_cyc immediately (asynchronously), and no ack SHALL be issued for the aborted transfer.
REQ-037 After deassertion, the first arbitration SHALL occur on the first rising edge with i_rst_n=1.

Verification
REQ-038 ibus only, adr=0x100, memory acks 3 cycles after o_mem_cyc rises with rdt=0xDEADBEEF -> o_mem_adr=0x100, sel=F, we=0; o_ibus_ack one cycle with rdt=0xDEADBEEF; o_dbus_ack stays 0.
REQ-039 Both requests high in the same cycle after reset with RR=1 -> ibus granted first, then dbus after its ack plus one IDLE cycle; with RR=0 -> dbus granted first.
REQ-040 dbus write adr=0x2000, dat=0x12345678, sel=0x3, and memory never acks, TIMEOUT=4 -> o_dbus_ack and o_err pulse on the 4th GNT cycle with rdt=0; FSM back in IDLE.
REQ-041 i_mem_ack on exactly the timeout cycle -> ack forwarded with i_mem_rdt and o_err=0.
REQ-042 i_rst_n pulsed low during GNT_D -> o_mem_cyc low the same cycle, no ack; after release, a pending ibus request is granted.
REQ-043 dbus drops cyc mid-grant, then memory acks -> o_dbus_ack stays 0; FSM returns to IDLE.

Source files
------------

// File: rtl/serv_mem_sched_if.sv
// Bus bundle between the SERV instruction/data buses, the shared memory port
// and the scheduler that arbitrates between them.
interface serv_mem_sched_if;
    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;

    logic [31:0] i_dbus_adr;
    logic [31:0] i_dbus_dat;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_cyc;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;

    logic [31:0] o_mem_adr;
    logic [31:0] o_mem_dat;
    logic [3:0]  o_mem_sel;
    logic        o_mem_we;
    logic        o_mem_cyc;
    logic [31:0] i_mem_rdt;
    logic        i_mem_ack;

    logic        o_err;
    logic        o_owner;

    modport slave (
        input  i_ibus_adr, i_ibus_cyc,
        input  i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        input  i_mem_rdt, i_mem_ack,
        output o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack,
        output o_mem_adr, o_mem_dat, o_mem_sel, o_mem_we, o_mem_cyc,
        output o_err, o_owner
    );

    modport master (
        output i_ibus_adr, i_ibus_cyc,
        output i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        output i_mem_rdt, i_mem_ack,
        input  o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack,
        input  o_mem_adr, o_mem_dat, o_mem_sel, o_mem_we, o_mem_cyc,
        input  o_err, o_owner
    );
endinterface

// File: rtl/serv_mem_sched.sv
// Arbitrates SERV ibus and dbus onto one shared memory port, one non-preemptible
// grant at a time, with an optional watchdog that error-acks stalled grants.
module serv_mem_sched #(
    parameter int unsigned TIMEOUT = 255,
    parameter bit          RR      = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    serv_mem_sched_if.slave  bus
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned ADR_W = 32;
    localparam int unsigned SEL_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               owner_q, owner_d;
    logic [ADR_W-1:0]   adr_q, adr_d, dat_q, dat_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               we_q, we_d;

    logic               in_gnt;
    logic               owner_cyc;
    logic               timeout_hit;
    logic               fin;
    logic               ack_c;
    logic               err_c;
    logic               pick_d;

    // Next-state, request capture and same-cycle completion decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        in_gnt      = (state_q != IDLE);
        owner_cyc   = (state_q == GNT_D) ? bus.i_dbus_cyc : bus.i_ibus_cyc;
        timeout_hit = (TIMEOUT != 0) && in_gnt && (cnt_q == CNT_LAST);
        fin         = in_gnt && (bus.i_mem_ack || timeout_hit);
        ack_c       = fin && owner_cyc;
        err_c       = timeout_hit && !bus.i_mem_ack;
        // On a tie, round-robin hands the port to whoever did not own it last
        pick_d      = !bus.i_ibus_cyc || (bus.i_dbus_cyc && (!RR || !owner_q));

        case (state_q)
            IDLE: begin
                if (bus.i_ibus_cyc || bus.i_dbus_cyc) begin
                    cnt_d = '0;
                    if (pick_d) begin
                        state_d = GNT_D;
                        owner_d = 1'b1;
                        adr_d   = bus.i_dbus_adr;
                        dat_d   = bus.i_dbus_dat;
                        sel_d   = bus.i_dbus_sel;
                        we_d    = bus.i_dbus_we;
                    end else begin
                        state_d = GNT_I;
                        owner_d = 1'b0;
                        adr_d   = bus.i_ibus_adr;
                        dat_d   = '0;
                        sel_d   = '1;
                        we_d    = 1'b0;
                    end
                end
            end
            GNT_I, GNT_D: begin
                if (fin) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b1;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
        end
    end

    // Acks and read data are steered combinationally from the memory strobe
    assign bus.o_mem_cyc  = in_gnt;
    assign bus.o_mem_adr  = adr_q;
    assign bus.o_mem_dat  = dat_q;
    assign bus.o_mem_sel  = sel_q;
    assign bus.o_mem_we   = we_q;
    assign bus.o_owner    = owner_q;
    assign bus.o_err      = err_c;
    assign bus.o_ibus_ack = ack_c && (state_q == GNT_I);
    assign bus.o_dbus_ack = ack_c && (state_q == GNT_D);
    assign bus.o_ibus_rdt = (ack_c && (state_q == GNT_I) && bus.i_mem_ack) ? bus.i_mem_rdt : '0;
    assign bus.o_dbus_rdt = (ack_c && (state_q == GNT_D) && bus.i_mem_ack) ? bus.i_mem_rdt : '0;
endmodule
